// File: rtl/exu_csr_regfile_pkg.sv
// Shared CSR addresses, bit positions and WARL masks for the machine-mode CSR file.
// Used by exu_csr_regfile and csr_counter64.
package exu_csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK    = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK     = 32'hFFFF_FFFC;

  // MPP is hard-wired to machine mode; only MIE/MPIE have storage.
  function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
    logic [31:0] v;
    v = MSTATUS_MPP_RO;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/exu_csr_regfile_csr_counter64.sv
// 64-bit CSR counter with independently writable halves.
// A low-half write freezes the high half; a high-half write drops the low-half carry.
module csr_counter64
  import exu_csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [32:0] lo_sum;

  assign lo_sum = {1'b0, lo} + {32'b0, inc};

  // NOTE: non-blocking assignments so both halves update from their pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lo <= '0;
      hi <= '0;
    end else begin
      lo <= we_lo ? wdata : lo_sum[31:0];
      if (we_hi)
        hi <= wdata;
      else if (!we_lo)
        hi <= hi + {31'b0, lo_sum[32]};
    end
  end

endmodule

// File: rtl/exu_csr_regfile.sv
// Machine-mode CSR register file: software writes, trap/mret updates, interrupt pending.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters; otherwise they read 0.
module exu_csr_regfile
  import exu_csr_regfile_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        inst_retire_i,
  input  logic        trap_we_i,
  input  logic [31:0] trap_mepc_i,
  input  logic [31:0] trap_mcause_i,
  input  logic [31:0] trap_mtval_i,
  input  logic        mret_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        int_pending_o
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip;
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;

  assign wr_mstatus  = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
  assign wr_mie      = csr_we_i && (csr_waddr_i == CSR_MIE);
  assign wr_mtvec    = csr_we_i && (csr_waddr_i == CSR_MTVEC);
  assign wr_mscratch = csr_we_i && (csr_waddr_i == CSR_MSCRATCH);
  assign wr_mepc     = csr_we_i && (csr_waddr_i == CSR_MEPC);
  assign wr_mcause   = csr_we_i && (csr_waddr_i == CSR_MCAUSE);
  assign wr_mtval    = csr_we_i && (csr_waddr_i == CSR_MTVAL);

  always_comb begin
    mip           = '0;
    mip[MIP_MSIP] = irq_sw_i;
    mip[MIP_MTIP] = irq_timer_i;
    mip[MIP_MEIP] = irq_ext_i;
  end

  // Trap entry owns mstatus/mepc/mcause/mtval that cycle; mret outranks a mstatus write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      if (wr_mie)      mie_q      <= csr_wdata_i & MIE_WMASK;
      if (wr_mtvec)    mtvec_q    <= csr_wdata_i & MTVEC_WMASK;
      if (wr_mscratch) mscratch_q <= csr_wdata_i;
      if (trap_we_i) begin
        mepc_q       <= trap_mepc_i & MEPC_WMASK;
        mcause_q     <= trap_mcause_i;
        mtval_q      <= trap_mtval_i;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (wr_mepc)   mepc_q   <= csr_wdata_i & MEPC_WMASK;
        if (wr_mcause) mcause_q <= csr_wdata_i;
        if (wr_mtval)  mtval_q  <= csr_wdata_i;
        if (mret_i) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie  <= csr_wdata_i[MSTATUS_MIE];
          mstatus_mpie <= csr_wdata_i[MSTATUS_MPIE];
        end
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (csr_we_i && (csr_waddr_i == CSR_MCYCLE)),
    .we_hi (csr_we_i && (csr_waddr_i == CSR_MCYCLEH)),
    .wdata (csr_wdata_i),
    .lo    (mcycle_lo),
    .hi    (mcycle_hi)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire_i),
    .we_lo (csr_we_i && (csr_waddr_i == CSR_MINSTRET)),
    .we_hi (csr_we_i && (csr_waddr_i == CSR_MINSTRETH)),
    .wdata (csr_wdata_i),
    .lo    (minstret_lo),
    .hi    (minstret_hi)
  );
`else
  logic unused_inst_retire;

  assign unused_inst_retire = inst_retire_i;
  assign mcycle_lo   = '0;
  assign mcycle_hi   = '0;
  assign minstret_lo = '0;
  assign minstret_hi = '0;
`endif

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      CSR_MSTATUS:   csr_rdata_o = pack_mstatus(mstatus_mie, mstatus_mpie);
      CSR_MISA:      csr_rdata_o = MISA_VALUE;
      CSR_MIE:       csr_rdata_o = mie_q;
      CSR_MTVEC:     csr_rdata_o = mtvec_q;
      CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
      CSR_MEPC:      csr_rdata_o = mepc_q;
      CSR_MCAUSE:    csr_rdata_o = mcause_q;
      CSR_MTVAL:     csr_rdata_o = mtval_q;
      CSR_MIP:       csr_rdata_o = mip;
      CSR_MCYCLE:    csr_rdata_o = mcycle_lo;
      CSR_MCYCLEH:   csr_rdata_o = mcycle_hi;
      CSR_MINSTRET:  csr_rdata_o = minstret_lo;
      CSR_MINSTRETH: csr_rdata_o = minstret_hi;
      CSR_MHARTID:   csr_rdata_o = HART_ID;
      default:       csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign int_pending_o = mstatus_mie & |(mie_q & mip);

endmodule
